// File: rtl/dht_pkg.sv
// Shared types, frame layout and timing defaults for the DHT11 single-wire reader.
package dht_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_LOW = 3'd1,
    RELEASE   = 3'd2,
    RESP_LOW  = 3'd3,
    RESP_HIGH = 3'd4,
    BIT_LOW   = 3'd5,
    BIT_HIGH  = 3'd6,
    CHECK     = 3'd7
  } dht_state_e;

  localparam int B_HUM_INT  = 0;
  localparam int B_HUM_DEC  = 1;
  localparam int B_TEMP_INT = 2;
  localparam int B_TEMP_DEC = 3;
  localparam int B_CSUM     = 4;
  localparam int FRAME_BITS = 40;

  localparam int T_START_DEF   = 18000;
  localparam int T_RELEASE_DEF = 30;
  localparam int T_THRESH_DEF  = 50;
  localparam int T_TIMEOUT_DEF = 200;
  localparam int CNT_W_DEF     = 16;

  // Byte 0 is the first byte on the wire, so it sits in the top of the MSB-first shift register.
  function automatic logic [7:0] frame_byte(input logic [39:0] frame, input int idx);
    return frame[8*(4-idx) +: 8];
  endfunction

  function automatic logic csum_ok(input logic [39:0] frame);
    logic [7:0] sum;
    sum = frame_byte(frame, B_HUM_INT) + frame_byte(frame, B_HUM_DEC) +
          frame_byte(frame, B_TEMP_INT) + frame_byte(frame, B_TEMP_DEC);
    return (sum == frame_byte(frame, B_CSUM));
  endfunction

endpackage

// File: rtl/dht_sync.sv
// Two-flop synchronizer for the asynchronous data line, with single-cycle rise/fall strobes.
module dht_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Resets high so an idle (pulled-up) line produces no spurious edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/dht11_reader.sv
// DHT11 host reader: start pulse, response handshake, 40-bit capture, checksum and publish.
module dht11_reader
  import dht_pkg::*;
#(
  parameter int T_START   = T_START_DEF,
  parameter int T_RELEASE = T_RELEASE_DEF,
  parameter int T_THRESH  = T_THRESH_DEF,
  parameter int T_TIMEOUT = T_TIMEOUT_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic       slow_clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic       busy,
  output logic       valid,
  output logic [7:0] humidity,
  output logic [7:0] temperature,
  output logic       checksum_err,
  output logic       timeout_err
);

  localparam logic [CNT_W-1:0] L_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_START_LAST = CNT_W'(T_START - 1);
  localparam logic [CNT_W-1:0] L_REL_TO     = CNT_W'(T_RELEASE + T_TIMEOUT);
  localparam logic [CNT_W-1:0] L_TO         = CNT_W'(T_TIMEOUT);
  localparam logic [CNT_W-1:0] L_THRESH     = CNT_W'(T_THRESH);
  localparam logic [5:0]       L_LAST_BIT   = 6'(FRAME_BITS - 1);

  dht_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc, w_limit, w_width;
  logic [5:0]        r_bit, w_bit_nxt;
  logic [39:0]       r_data, w_data_nxt;
  logic [7:0]        r_hum, w_hum_nxt, r_temp, w_temp_nxt;
  logic              r_oe, r_busy, r_valid, w_valid_nxt;
  logic              r_cs_err, w_cs_nxt, r_to_err, w_to_nxt;
  logic              w_level, w_rise, w_fall, w_timeout, w_bit_val;

  dht_sync u_sync (
    .clk     (slow_clk),
    .rst_n   (rst_n),
    .i_d     (dht_in),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + L_ONE;
  assign w_limit   = (r_state == RELEASE) ? L_REL_TO : L_TO;
  assign w_timeout = (r_cnt >= w_limit);
  // The rise cycle itself is high but not counted, so the high width is one more than the count.
  assign w_width   = r_cnt + L_ONE;
  assign w_bit_val = (w_width > L_THRESH);

  // Next-state, counters, capture and result flags.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_data_nxt  = r_data;
    w_hum_nxt   = r_hum;
    w_temp_nxt  = r_temp;
    w_valid_nxt = 1'b0;
    w_cs_nxt    = r_cs_err;
    w_to_nxt    = r_to_err;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = START_LOW;
          w_cnt_nxt   = '0;
          w_cs_nxt    = 1'b0;
          w_to_nxt    = 1'b0;
        end else begin
          w_cnt_nxt = '0;
        end
      end
      START_LOW: begin
        if (r_cnt == L_START_LAST) begin
          w_state_nxt = RELEASE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW: begin
        if ((r_state == RELEASE) && w_fall) begin
          w_state_nxt = RESP_LOW;
          w_cnt_nxt   = '0;
        end else if ((r_state == RESP_LOW) && w_rise) begin
          w_state_nxt = RESP_HIGH;
          w_cnt_nxt   = '0;
        end else if ((r_state == RESP_HIGH) && w_fall) begin
          w_state_nxt = BIT_LOW;
          w_cnt_nxt   = '0;
          w_bit_nxt   = 6'd0;
        end else if ((r_state == BIT_LOW) && w_rise) begin
          w_state_nxt = BIT_HIGH;
          w_cnt_nxt   = '0;
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
          w_to_nxt    = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      BIT_HIGH: begin
        if (w_fall) begin
          w_data_nxt = {r_data[38:0], w_bit_val};
          w_cnt_nxt  = '0;
          if (r_bit == L_LAST_BIT) begin
            w_state_nxt = CHECK;
          end else begin
            w_state_nxt = BIT_LOW;
            w_bit_nxt   = r_bit + 6'd1;
          end
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
          w_to_nxt    = 1'b1;
        end else if (w_level) begin
          w_cnt_nxt = w_cnt_inc;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      CHECK: begin
        w_state_nxt = IDLE;
        if (csum_ok(r_data)) begin
          w_hum_nxt   = frame_byte(r_data, B_HUM_INT);
          w_temp_nxt  = frame_byte(r_data, B_TEMP_INT);
          w_valid_nxt = 1'b1;
        end else begin
          w_cs_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; line drive and busy follow the next state so they align with it.
  always_ff @(posedge slow_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_bit    <= 6'd0;
      r_data   <= 40'd0;
      r_hum    <= 8'd0;
      r_temp   <= 8'd0;
      r_oe     <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_cs_err <= 1'b0;
      r_to_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bit    <= w_bit_nxt;
      r_data   <= w_data_nxt;
      r_hum    <= w_hum_nxt;
      r_temp   <= w_temp_nxt;
      r_oe     <= (w_state_nxt == START_LOW);
      r_busy   <= (w_state_nxt != IDLE);
      r_valid  <= w_valid_nxt;
      r_cs_err <= w_cs_nxt;
      r_to_err <= w_to_nxt;
    end
  end

  assign dht_oe       = r_oe;
  assign busy         = r_busy;
  assign valid        = r_valid;
  assign humidity     = r_hum;
  assign temperature  = r_temp;
  assign checksum_err = r_cs_err;
  assign timeout_err  = r_to_err;

endmodule

// File: tb/tb_dht11_reader.sv
// Scoreboard bench for dht11_reader: a sensor model drives the line, a monitor checks each completed read.
module tb_dht11_reader;

  localparam int TB_T_START = 3000;

  typedef struct {
    logic       v;
    logic       cs;
    logic       to;
    logic [7:0] h;
    logic [7:0] t;
  } exp_t;

  logic       slow_clk = 1'b0;
  logic       rst_n    = 1'b0;
  logic       start    = 1'b0;
  logic       sens_low = 1'b0;
  logic       dht_in;
  logic       dht_oe, busy, valid, checksum_err, timeout_err;
  logic [7:0] humidity, temperature;

  int   hw[40];
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  logic pb = 1'b0;
  logic pv = 1'b0;

  assign dht_in = dht_oe ? 1'b0 : ~sens_low;

  dht11_reader #(.T_START(TB_T_START)) dut (
    .slow_clk     (slow_clk),
    .rst_n        (rst_n),
    .start        (start),
    .dht_in       (dht_in),
    .dht_oe       (dht_oe),
    .busy         (busy),
    .valid        (valid),
    .humidity     (humidity),
    .temperature  (temperature),
    .checksum_err (checksum_err),
    .timeout_err  (timeout_err)
  );

  always #5 slow_clk = ~slow_clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge slow_clk);
  endtask

  task automatic push(input logic v, input logic cs, input logic to, input logic [7:0] h, input logic [7:0] t);
    exp_t e;
    e.v = v; e.cs = cs; e.to = to; e.h = h; e.t = t;
    q.push_back(e);
  endtask

  task automatic fill(input logic [39:0] f);
    for (int i = 0; i < 40; i++) hw[i] = f[39-i] ? 70 : 27;
  endtask

  // Issue start and measure how long the line is driven low; optionally re-pulse start mid-way.
  task automatic read_start(input bit restart);
    int n;
    @(negedge slow_clk);
    start = 1'b1;
    @(negedge slow_clk);
    start = 1'b0;
    n = 0;
    while (dht_oe === 1'b1 && n < TB_T_START + 100) begin
      n++;
      @(negedge slow_clk);
      start = (restart && n == 100);
    end
    start = 1'b0;
    chk("start_low_width", n, TB_T_START);
  endtask

  // Sensor model: response handshake then bits; stops before bit stop_bit when that is in range.
  task automatic send(input int stop_bit);
    ticks(20);
    sens_low = 1'b1; ticks(80);
    sens_low = 1'b0; ticks(80);
    for (int i = 0; i < 40; i++) begin
      if (i == stop_bit) begin
        sens_low = 1'b0;
        return;
      end
      sens_low = 1'b1; ticks(50);
      sens_low = 1'b0; ticks(hw[i]);
    end
    sens_low = 1'b1; ticks(50);
    sens_low = 1'b0; ticks(5);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge slow_clk);
    end
    if (n >= 1000) chk("busy_release_bound", busy, 0);
    ticks(3);
  endtask

  // Monitor: every busy fall outside reset is one completed read, compared against the queue head.
  always @(negedge slow_clk) begin
    if (!rst_n) begin
      pb <= 1'b0;
      pv <= 1'b0;
    end else begin
      if (pv) chk("valid_one_cycle", valid, 0);
      if (pb && !busy) begin
        if (q.size() == 0) begin
          chk("unexpected_completion", 1, 0);
        end else begin
          chk("valid", valid, q[0].v);
          chk("checksum_err", checksum_err, q[0].cs);
          chk("timeout_err", timeout_err, q[0].to);
          chk("humidity", humidity, q[0].h);
          chk("temperature", temperature, q[0].t);
          q.pop_front();
        end
      end
      pb <= busy;
      pv <= valid;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    ticks(3);
    chk("reset_oe", dht_oe, 0);
    chk("reset_busy", busy, 0);
    chk("reset_data", {humidity, temperature}, 0);
    chk("reset_errs", {checksum_err, timeout_err, valid}, 0);
    rst_n = 1'b1;
    ticks(5);

    // Good frame
    fill(40'h36_00_19_00_4F);
    push(1'b1, 1'b0, 1'b0, 8'd54, 8'd25);
    read_start(1'b0);
    send(-1);
    wait_idle();

    // Bad checksum keeps old data
    fill(40'h36_00_19_00_50);
    push(1'b0, 1'b1, 1'b0, 8'd54, 8'd25);
    read_start(1'b0);
    send(-1);
    wait_idle();

    // No sensor: release-phase timeout after T_RELEASE+T_TIMEOUT ticks
    push(1'b0, 1'b0, 1'b1, 8'd54, 8'd25);
    read_start(1'b0);
    n = 0;
    while (timeout_err !== 1'b1 && n < 1000) begin
      n++;
      @(negedge slow_clk);
    end
    chk("release_timeout_ticks", n, 231);
    chk("busy_after_timeout", busy, 0);
    wait_idle();

    // Threshold boundary (50 -> 0, 51 -> 1) with a start re-pulse while busy
    fill(40'h40_00_14_00_54);
    hw[0] = 50;
    hw[1] = 51;
    push(1'b1, 1'b0, 1'b0, 8'd64, 8'd20);
    read_start(1'b1);
    send(-1);
    wait_idle();

    // Stalled bit 12
    fill(40'h36_00_19_00_4F);
    hw[12] = 250;
    push(1'b0, 1'b0, 1'b1, 8'd64, 8'd20);
    read_start(1'b0);
    send(13);
    wait_idle();
    chk("valid_after_stall", valid, 0);

    // Mid-frame reset at bit index 20, checked before the next clock edge
    fill(40'h36_00_19_00_4F);
    read_start(1'b0);
    send(20);
    sens_low = 1'b1;
    ticks(10);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_oe", dht_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_humidity", humidity, 0);
    chk("rst_temperature", temperature, 0);
    ticks(3);
    rst_n = 1'b1;
    sens_low = 1'b0;
    ticks(5);
    push(1'b1, 1'b0, 1'b0, 8'd54, 8'd25);
    read_start(1'b0);
    send(-1);
    wait_idle();

    ticks(20);
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
